// File: rtl/ar_tx_sched.sv
// Round-robin scheduler sharing one ARINC 429 word transmitter among NUM_REQ requesters.
// Define AR_TX_SCHED_TIMEOUT_EN to add the start/word watchdog that drives err_to.
module ar_tx_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned GAP_CE   = 0,
  parameter int unsigned START_TO = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  req_adr,
  input  logic [23*NUM_REQ-1:0] req_dat,
  input  logic [1:0]            cfg_nvel,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  tx_st,
  output logic [7:0]            tx_adr,
  output logic [22:0]           tx_dat,
  output logic [1:0]            tx_nvel,
  input  logic                  tx_ce,
  input  logic                  tx_busy,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  err_to
);
  localparam int unsigned IW = 3;
  localparam int unsigned GW = 4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CE > 15 || START_TO < 2 || START_TO > 7) begin : g_bad_param
    $error("ar_tx_sched: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx;
  logic [GW-1:0]       gap_cnt, gap_nx;
  logic [NUM_REQ-1:0]  ack_nx;
  logic                tx_st_nx;
  logic [7:0]          adr_nx;
  logic [22:0]         dat_nx;
  logic [1:0]          nvel_nx;
  logic [IW-1:0]       gid_nx;
  logic                busy_nx;
  logic [IW-1:0]       sel_idx;
  logic [7:0]          sel_adr;
  logic [22:0]         sel_dat;
  int unsigned         best_d, cur_d;

`ifdef AR_TX_SCHED_TIMEOUT_EN
  logic [2:0] to_cnt, to_nx;
  logic [5:0] wd_cnt, wd_nx;
  logic       err_nx;
`endif

  // Pick the set request closest to ptr going upward with wrap.
  always_comb begin
    sel_idx = '0;
    sel_adr = '0;
    sel_dat = '0;
    best_d  = NUM_REQ;
    cur_d   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cur_d = (i + NUM_REQ - 32'(ptr)) % NUM_REQ;
      if (req[i] && cur_d < best_d) begin
        best_d  = cur_d;
        sel_idx = IW'(i);
        sel_adr = req_adr[8*i +: 8];
        sel_dat = req_dat[23*i +: 23];
      end
    end
  end

  // Outputs are computed from the next state so they are registered yet line up with it.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gap_nx   = gap_cnt;
    ack_nx   = '0;
    tx_st_nx = 1'b0;
    adr_nx   = tx_adr;
    dat_nx   = tx_dat;
    nvel_nx  = tx_nvel;
    gid_nx   = grant_id;
`ifdef AR_TX_SCHED_TIMEOUT_EN
    to_nx    = to_cnt;
    wd_nx    = wd_cnt;
    err_nx   = err_to;
`endif
    unique case (state)
      S_IDLE: begin
        if ((|req) && !tx_busy) begin
          state_nx = S_GRANT;
          ack_nx   = NUM_REQ'(1) << sel_idx;
          adr_nx   = sel_adr;
          dat_nx   = sel_dat;
          nvel_nx  = cfg_nvel;
          gid_nx   = sel_idx;
          ptr_nx   = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      S_GRANT: begin
        state_nx = S_START;
        tx_st_nx = 1'b1;
      end
      S_START: begin
        state_nx = S_WAIT_BUSY;
`ifdef AR_TX_SCHED_TIMEOUT_EN
        // The start clock itself already counts toward the timeout.
        to_nx    = 3'd1;
        wd_nx    = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = S_WAIT_DONE;
`ifdef AR_TX_SCHED_TIMEOUT_EN
        end else if (to_cnt == 3'(START_TO - 1)) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          to_nx    = to_cnt + 1'b1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nx = (GAP_CE > 0) ? S_GAP : S_IDLE;
          gap_nx   = '0;
`ifdef AR_TX_SCHED_TIMEOUT_EN
        end else if (tx_ce) begin
          if (wd_cnt == 6'd40) begin
            err_nx   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            wd_nx    = wd_cnt + 1'b1;
          end
`endif
        end
      end
      S_GAP: begin
        if (tx_ce) begin
          if (gap_cnt == GW'(GAP_CE - 1)) state_nx = S_IDLE;
          else                            gap_nx   = gap_cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gap_cnt  <= '0;
      ack      <= '0;
      tx_st    <= 1'b0;
      tx_adr   <= '0;
      tx_dat   <= '0;
      tx_nvel  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gap_cnt  <= gap_nx;
      ack      <= ack_nx;
      tx_st    <= tx_st_nx;
      tx_adr   <= adr_nx;
      tx_dat   <= dat_nx;
      tx_nvel  <= nvel_nx;
      grant_id <= gid_nx;
      busy     <= busy_nx;
    end
  end

`ifdef AR_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      wd_cnt <= '0;
      err_to <= 1'b0;
    end else begin
      to_cnt <= to_nx;
      wd_cnt <= wd_nx;
      err_to <= err_nx;
    end
  end
`else
  assign err_to = 1'b0;
`endif

endmodule

// File: tb/tb_ar_tx_sched.sv
// Self-checking bench for ar_tx_sched: directed steps plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ar_tx_sched;
  localparam int unsigned NR  = 4;
  localparam int unsigned GAP = 4;
  localparam int unsigned STO = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req;
  logic [8*NR-1:0]      req_adr;
  logic [23*NR-1:0]     req_dat;
  logic [1:0]           cfg_nvel;
  logic [NR-1:0]        ack;
  logic                 tx_st;
  logic [7:0]           tx_adr;
  logic [22:0]          tx_dat;
  logic [1:0]           tx_nvel;
  logic                 tx_ce;
  logic                 tx_busy;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err_to;

  ar_tx_sched #(.NUM_REQ(NR), .GAP_CE(GAP), .START_TO(STO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_dat(req_dat),
    .cfg_nvel(cfg_nvel), .ack(ack), .tx_st(tx_st), .tx_adr(tx_adr), .tx_dat(tx_dat),
    .tx_nvel(tx_nvel), .tx_ce(tx_ce), .tx_busy(tx_busy), .grant_id(grant_id),
    .busy(busy), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0]  adr_m[$];
  logic [22:0] dat_m[$];
  int grants[$];
  int m_ptr, words, policy, in_word, gap_state, gap_cnt_m, gap_done_cyc;
  int fall_cyc, req_set_cyc, ack_cyc, st_cyc, tph, tcnt, base;
  bit tx_dead;
  logic [7:0]  lat_adr;
  logic [22:0] lat_dat;
  logic [1:0]  lat_nvel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    req_adr = '0;
    req_dat = '0;
    for (int i = 0; i < NR; i++) begin
      req_adr = req_adr | ((8*NR)'(adr_m[i]) << (8*i));
      req_dat = req_dat | ((23*NR)'(dat_m[i]) << (23*i));
    end
  endtask

  // One clock: check outputs against the model, then advance requesters and transmitter.
  task automatic tick();
    int e, j;
    @(posedge clk); #1; cyc++;
    if (ack != '0) begin
      e = -1;
      for (int k = 0; k < NR; k++)
        if (e < 0 && ((32'(req) >> ((m_ptr + k) % NR)) & 32'd1) != 0) e = (m_ptr + k) % NR;
      chk("ack_onehot", 32'(ack), (e < 0) ? 32'd0 : (32'd1 << e));
      if (e >= 0) begin
        chk("grant_id", 32'(grant_id), 32'(e));
        chk("tx_adr", 32'(tx_adr), 32'(adr_m[e]));
        chk("tx_dat", 32'(tx_dat), 32'(dat_m[e]));
        chk("tx_nvel", 32'(tx_nvel), 32'(cfg_nvel));
        chk("ack_tx_idle", 32'(tx_busy), 32'd0);
        chk("busy_at_ack", 32'(busy), 32'd1);
        if (gap_state != 0) begin
          chk("gap_complete", 32'(gap_state), 32'd2);
          if (gap_state == 2) begin
            if (policy == 0 && req_set_cyc <= gap_done_cyc) chk("gap_ack_cyc", 32'(cyc), 32'(gap_done_cyc + 2));
            else chk("gap_ack_late", 32'(cyc >= gap_done_cyc + 2), 32'd1);
          end
        end
        lat_adr = adr_m[e]; lat_dat = dat_m[e]; lat_nvel = cfg_nvel;
        m_ptr = (e + 1) % NR; ack_cyc = cyc; in_word = 1; gap_state = 0;
        words++; grants.push_back(e);
        if (policy == 1 || (policy == 2 && $urandom_range(0, 1) == 0)) begin
          req = req & ~(NR'(1) << e);
        end else if (policy == 2) begin
          adr_m[e] = 8'($urandom); dat_m[e] = 23'($urandom);
        end
      end
    end else if (busy === 1'b1) begin
      chk("hold_adr", 32'(tx_adr), 32'(lat_adr));
      chk("hold_dat", 32'(tx_dat), 32'(lat_dat));
      chk("hold_nvel", 32'(tx_nvel), 32'(lat_nvel));
    end
    if (cyc == ack_cyc + 1) chk("st_pulse", 32'(tx_st), 32'd1);
    if (tx_st === 1'b1) begin
      chk("st_after_ack", 32'(cyc), 32'(ack_cyc + 1));
      chk("st_tx_idle", 32'(tx_busy), 32'd0);
      st_cyc = cyc;
    end
    if (in_word != 0 && tx_busy) chk("busy_during_word", 32'(busy), 32'd1);
    // Transmitter model: busy a few clocks after start, held for a random word time.
    if (tx_st === 1'b1 && !tx_dead) begin tph = 1; tcnt = $urandom_range(0, 2); end
    if (tph == 1) begin
      if (tcnt == 0) begin tx_busy = 1'b1; tph = 2; tcnt = $urandom_range(3, 10); end
      else tcnt--;
    end else if (tph == 2) begin
      if (tcnt == 0) begin
        tx_busy = 1'b0; tph = 0; fall_cyc = cyc;
        if (in_word != 0) begin gap_state = 1; gap_cnt_m = 0; end
        in_word = 0;
      end else tcnt--;
    end
    tx_ce = ($urandom_range(0, 2) == 0);
    if (gap_state == 1 && cyc > fall_cyc && tx_ce) begin
      gap_cnt_m++;
      if (gap_cnt_m == GAP) begin gap_state = 2; gap_done_cyc = cyc; end
    end
    if (policy == 2 && $urandom_range(0, 5) == 0) begin
      j = $urandom_range(0, NR - 1);
      if (((32'(req) >> j) & 32'd1) == 0) begin
        adr_m[j] = 8'($urandom); dat_m[j] = 23'($urandom);
        req = req | (NR'(1) << j);
      end
    end
    pack();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_word = 0; gap_state = 0;
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_st", 32'(tx_st), 32'd0);
    chk("rst_tx_adr", 32'(tx_adr), 32'd0);
    chk("rst_tx_dat", 32'(tx_dat), 32'd0);
    chk("rst_tx_nvel", 32'(tx_nvel), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_to", 32'(err_to), 32'd0);
    rst = 1'b0; m_ptr = 0; ack_cyc = -10;
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int n = 0; n < budget && words < target; n++) tick();
    chk("words_reached", 32'(words), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && !(busy == 1'b0 && tph == 0); n++) tick();
    chk("idle_reached", 32'(busy == 1'b0 && tph == 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; cfg_nvel = 2'd3; tx_ce = 1'b0; tx_busy = 1'b0;
    tph = 0; tcnt = 0; tx_dead = 1'b0; policy = 1; ack_cyc = -10; st_cyc = 0;
    gap_state = 0; gap_cnt_m = 0; gap_done_cyc = 0; fall_cyc = 0; in_word = 0;
    m_ptr = 0; words = 0; req_set_cyc = 0;
    for (int i = 0; i < NR; i++) begin
      adr_m.push_back(8'(8'h10 + i)); dat_m.push_back(23'(23'h100 * (i + 1)));
    end
    pack();
    do_reset();
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Round robin with all requests held; speed code changed mid-word.
    policy = 0; grants.delete(); base = words;
    req = 4'b1111; req_set_cyc = cyc;
    wait_words(base + 2, 200);
    for (int n = 0; n < 50 && !tx_busy; n++) tick();
    chk("rr_tx_busy_seen", 32'(tx_busy), 32'd1);
    cfg_nvel = 2'd0;
    tick();
    chk("nvel_hold", 32'(tx_nvel), 32'd3);
    wait_words(base + 3, 200);
    chk("nvel_new", 32'(tx_nvel), 32'd0);
    wait_words(base + 8, 800);
    req = '0;
    for (int k = 0; k < 8; k++) chk("rr_order", 32'(grants[k]), 32'(k % NR));
    wait_idle(200);

    // Single request latency and data.
    cfg_nvel = 2'd3; policy = 1;
    adr_m[0] = 8'hA5; dat_m[0] = 23'h12345; pack();
    req = 4'b0001; req_set_cyc = cyc;
    tick();
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_adr", 32'(tx_adr), 32'hA5);
    chk("single_dat", 32'(tx_dat), 32'h12345);
    chk("single_nvel", 32'(tx_nvel), 32'd3);
    tick();
    chk("single_st", 32'(tx_st), 32'd1);
    chk("single_ack_low", 32'(ack), 32'd0);
    wait_idle(200);

    // Reset while the transmitter is mid-word.
    req = 4'b0001; req_set_cyc = cyc;
    wait_words(words + 1, 20);
    for (int n = 0; n < 50 && tph != 2; n++) tick();
    tcnt = 8; req = 4'b0010;
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();
    for (int n = 0; n < 40 && ack == '0; n++) tick();
    chk("rst_regrant_ack", 32'(ack), 32'b0010);
    chk("rst_regrant_cyc", 32'(cyc), 32'(fall_cyc + 1));
    wait_idle(200);

    // Random traffic.
    policy = 2; req = NR'($urandom); req_set_cyc = cyc;
    wait_words(words + 30, 3000);
    policy = 1; req = '0;
    wait_idle(200);

`ifdef AR_TX_SCHED_TIMEOUT_EN
    // Transmitter never answers: start timeout.
    tx_dead = 1'b1; req = 4'b0001;
    for (int n = 0; n < 20 && err_to !== 1'b1; n++) tick();
    chk("to_err", 32'(err_to), 32'd1);
    chk("to_cyc", 32'(cyc), 32'(st_cyc + STO));
    chk("to_idle", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("to_sticky", 32'(err_to), 32'd1);
    tx_dead = 1'b0;
    do_reset();
`else
    chk("err_to_tied", 32'(err_to), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ar_tx_sched.md
Name: ar_tx_sched

Overview:
- Round-robin scheduler that shares one ARINC 429 word transmitter between NUM_REQ requesters.
- Each requester presents an 8-bit label/address and a 23-bit data field with a req/ack handshake.
- The scheduler grants one requester and latches its word and the line speed code. It then issues a single-cycle start to the transmitter, follows the transmitter's busy flag through to the end of the word, and inserts a programmable inter-word gap before the next grant.
- Sits between the host-side word sources and the transmitter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CE, 0, extra inter-word gap in transmitter bit-clock-enable ticks added after the transmitter drops busy (0..15).
- START_TO, 7, clocks allowed between start pulse and busy assertion before a start-timeout error (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester word-pending request, level.
- req_adr  in  8*NUM_REQ  per-requester label; slice i = bits [8i+7:8i].
- req_dat  in  23*NUM_REQ  per-requester data; slice i = bits [23i+22:23i].
- cfg_nvel  in  2  line speed code (3=1 Mb/s, 2=100 kb/s, 1=50 kb/s, 0=12.5 kb/s).
- ack  out  NUM_REQ  one-clock pulse to the granted requester when its word is latched.
- tx_st  out  1  one-clock start pulse to the transmitter.
- tx_adr  out  8  latched label to the transmitter.
- tx_dat  out  23  latched data to the transmitter.
- tx_nvel  out  2  latched speed code to the transmitter.
- tx_ce  in  1  transmitter bit clock enable.
- tx_busy  in  1  transmitter word-in-progress flag.
- grant_id  out  3  index of the current/last granted requester.
- busy  out  1  scheduler not in IDLE.
- err_to  out  1  sticky timeout error (optional feature only, else 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; gap counter 0. rst mid-word returns to IDLE immediately. The transmitter is not stopped, so after reset the block waits for tx_busy=0 before any new grant.
- States:
  - IDLE: if any req bit is set and tx_busy=0, go to GRANT.
  - GRANT (1 clk):
    - Select the first set req bit starting at pointer, searching upward with wrap.
    - Latch tx_adr, tx_dat and tx_nvel (from cfg_nvel); set grant_id; pulse ack[i].
    - Pointer becomes i+1 mod NUM_REQ. Go to START.
  - START (1 clk): tx_st=1. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. Go to GAP if GAP_CE>0, else IDLE.
  - GAP: count tx_ce pulses. When the count reaches GAP_CE, go to IDLE.
- Latency: req rising in IDLE gives ack on the next clock edge (GRANT) and tx_st one clock after ack.
- Requester rules:
  - A requester deasserts req or presents a new word after seeing its ack.
  - req dropped before ack is simply not granted; no error.
- Outputs are stable while busy:
  - tx_adr, tx_dat and tx_nvel hold from GRANT until the next GRANT.
  - cfg_nvel changes during a word take effect only at the next grant.
- Fairness: any requester held high is granted within NUM_REQ words.
- tx_st is never asserted while tx_busy=1.
- busy=1 in every state except IDLE.
- Only the granted requester is acknowledged, even when several req bits are set.

Optional Feature:
- Macro: AR_TX_SCHED_TIMEOUT_EN.
- Defined:
  - A 3-bit counter runs in WAIT_BUSY.
  - If tx_busy is still 0 after START_TO clocks, set err_to (sticky, cleared only by rst) and return to IDLE.
  - A further watchdog in WAIT_DONE counts tx_ce. If more than 40 tx_ce pulses pass without tx_busy falling, set err_to and go to IDLE.
- Undefined: no counters; WAIT_BUSY and WAIT_DONE wait indefinitely; err_to tied 0.

Test Plan:
- Single request: req=0001, adr=8'hA5, dat=23'h12345, cfg_nvel=3 -> ack=0001 one clock later, tx_st one clock after ack, tx_adr=A5, tx_dat=12345, tx_nvel=3; busy high until tx_busy falls.
- Round-robin: req=1111 held for 8 words -> grant order 0,1,2,3,0,1,2,3; exactly one ack per word.
- Gap: GAP_CE=4, two back-to-back words -> second tx_st occurs only after 4 tx_ce pulses following tx_busy falling.
- Speed latch: change cfg_nvel 3->0 during WAIT_DONE -> tx_nvel stays 3 until the next GRANT, then becomes 0.
- Reset mid-word: assert rst in WAIT_DONE while tx_busy=1 and req=0010 -> outputs 0; no grant until tx_busy=0; then ack=0010 (pointer restarted at 0).
- Timeout (macro defined, START_TO=7): transmitter model never raises tx_busy -> err_to=1 seven clocks after tx_st; state IDLE; err_to remains 1 until rst.
